lfsr_step_ctrl: RTL and testbench
=================================

// Module: lfsr_step_ctrl
// PURPOSE
//  Sequencer for the 8-bit XNOR-feedback LFSR shown on the two-digit seven-segment display.
//  Replaces direct clocking of the LFSR from a raw pin.
//  Takes a raw asynchronous step button, a run-mode switch and a seed-load request.
//  Issues single-cycle step/load strobes to the LFSR datapath, all in the clk domain.
//  Sits between board inputs and the LFSR register; also counts issued steps.
// PARAMETERS
//  DEB_CYCLES  16   cycles the synchronised step input must be stable to be accepted (>=2)
//  RUN_PERIOD  100  clk cycles between auto-run step strobes (>=2)
//  CNT_W       16   width of step_count
// PORTS
//  clk         in   1      system clock
//  rst         in   1      reset: asynchronous assert, active-high
//  step_in     in   1      raw step button, asynchronous, bounces
//  run_mode    in   1      1 = auto-run, 0 = manual stepping; level, treated synchronous
//  seed_req    in   1      level; rising edge requests a seed load
//  seed        in   8      seed value sampled when seed_req rises
//  lfsr_step   out  1      1-cycle strobe: LFSR advances one step
//  lfsr_load   out  1      1-cycle strobe: LFSR loads lfsr_seed
//  lfsr_seed   out  8      sanitised seed, valid while lfsr_load=1
//  state_o     out  2      current FSM state encoding (debug)
//  step_count  out  CNT_W  number of lfsr_step strobes issued since reset or last load
// BEHAVIOUR
//  Reset values (all outputs):
//   lfsr_step=0, lfsr_load=0, lfsr_seed=8'h01, state_o=S_MANUAL, step_count=0.
//   Sync/debounce/prescaler cleared; debounced level=0.
//  Input conditioning:
//   step_in passes through a 2-flop synchroniser.
//   The debounced level changes only after the synchronised value differs from it for DEB_CYCLES consecutive cycles.
//   Any glitch shorter than that restarts the stability count.
//  Step event: debounced 0->1 edge. lfsr_step is asserted in the cycle after the debounced level rises (S_MANUAL only).
//  Load event: seed_req 0->1 edge, detected from a registered copy of seed_req; no debounce.
//  Seed sanitisation: seed==8'hFF (XNOR lock-up state) is substituted with 8'h01; any other value passes unchanged.
//  States:
//   S_MANUAL (2'd0):
//    - Step event -> lfsr_step=1 for one cycle.
//    - run_mode=1 -> S_RUN, with the prescaler cleared.
//   S_RUN (2'd1):
//    - The prescaler counts 0..RUN_PERIOD-1.
//    - lfsr_step=1 in the cycle it wraps: first strobe RUN_PERIOD cycles after entry.
//    - Step events are ignored.
//    - run_mode=0 -> S_MANUAL; the prescaler is held at 0.
//   S_LOAD (2'd2), entered from any state on a load event:
//    - lfsr_load=1 and lfsr_seed valid for exactly one cycle.
//    - step_count is cleared to 0.
//    - Next state: S_RUN if run_mode=1, else S_MANUAL. S_RUN entered this way restarts the prescaler from 0.
//  Priority: load event > step/tick.
//   A step event or run tick coinciding with a load event is dropped, not deferred.
//   A step event arriving while in S_LOAD is also dropped.
//  lfsr_step and lfsr_load are never high together; each is at most 1 cycle wide.
//  step_count increments by 1 on every lfsr_step strobe and wraps from all-ones to 0.
//  A load event clears step_count; a reset also clears it. A reset mid-debounce or mid-period discards all progress.
//  State encoding 2'd3 is illegal and recovers to S_MANUAL on the next clock.
// STRUCTURE
//  Shared package (lfsr_pkg):
//   - state enum S_MANUAL/S_RUN/S_LOAD
//   - LFSR_RST_SEED=8'h01, LFSR_LOCK=8'hFF
//   - LFSR width constant 8
//  Sub-module debounce_sync: synchroniser plus stability counter; params DEB_CYCLES; ports clk, rst, din, dout.
//  The edge detectors, prescaler, FSM and step counter stay in this module.
// TESTING
//  1. Reset: rst=1 mid-sim -> all outputs at reset values immediately (asynchronous), before the next clk edge.
//  2. Bounce: step_in toggles every 3 cycles for 30 cycles, then held 1, DEB_CYCLES=16.
//     -> exactly one lfsr_step, 19 cycles (2 sync + 16 stable + 1) after the final 0->1 transition; step_count=1.
//  3. Auto-run: run_mode=1, RUN_PERIOD=100, run 1000 cycles.
//     -> 10 strobes, spaced exactly 100 apart, first at cycle 100; button presses produce no extra strobes.
//  4. Seed lock-up: seed=8'hFF, pulse seed_req -> one lfsr_load with lfsr_seed=8'h01; step_count=0.
//     seed=8'h5A -> lfsr_seed=8'h5A.
//  5. Collision: load event in the same cycle as a run tick.
//     -> lfsr_load=1, lfsr_step=0 that cycle; the next step follows RUN_PERIOD cycles after S_LOAD exits.
//  6. Wrap: CNT_W=4, issue 17 manual steps -> step_count reads 1; never lfsr_step&lfsr_load.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the seven-segment LFSR step sequencer.
// Holds the state encoding, the reset/lock-up seeds and the seed sanitiser.
package lfsr_pkg;

    localparam int LFSR_W = 8;

    localparam logic [LFSR_W-1:0] LFSR_RST_SEED = 8'h01;
    localparam logic [LFSR_W-1:0] LFSR_LOCK     = 8'hFF;

    typedef enum logic [1:0] {
        S_MANUAL = 2'd0,
        S_RUN    = 2'd1,
        S_LOAD   = 2'd2
    } state_t;

    // The all-ones pattern never leaves itself under XNOR feedback.
    function automatic logic [LFSR_W-1:0] sanitise_seed(input logic [LFSR_W-1:0] s);
        return (s == LFSR_LOCK) ? LFSR_RST_SEED : s;
    endfunction

endpackage

// File: rtl/lfsr_step_ctrl_debounce_sync.sv
// Two-flop synchroniser followed by a stability counter for the raw step button.
// The output level follows the synchronised input only after it has differed for DEB_CYCLES cycles.
module debounce_sync #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            // Any cycle where the input agrees with the level restarts the count.
            if (r_sync2 != r_level) begin
                if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign dout = r_level;

endmodule

// File: rtl/lfsr_step_ctrl.sv
// Step/load sequencer for the 8-bit XNOR LFSR: manual stepping, auto-run and seed loads,
// issued as single-cycle strobes with a running count of steps.
module lfsr_step_ctrl
    import lfsr_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int RUN_PERIOD = 100,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_in,
    input  logic              run_mode,
    input  logic              seed_req,
    input  logic [LFSR_W-1:0] seed,
    output logic              lfsr_step,
    output logic              lfsr_load,
    output logic [LFSR_W-1:0] lfsr_seed,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  step_count
);
    localparam int PW = (RUN_PERIOD > 2) ? $clog2(RUN_PERIOD) : 1;

    logic              w_deb;
    logic              w_step_event;
    logic              w_load_event;
    logic              r_deb_d;
    logic              r_seed_req;
    state_t            r_state;
    logic [PW-1:0]     r_presc;
    logic              r_step;
    logic              r_load;
    logic [LFSR_W-1:0] r_seed;
    logic [CNT_W-1:0]  r_count;

    debounce_sync #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
        .clk  (clk),
        .rst  (rst),
        .din  (step_in),
        .dout (w_deb)
    );

    assign w_step_event = w_deb & ~r_deb_d;
    assign w_load_event = seed_req & ~r_seed_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb_d    <= 1'b0;
            r_seed_req <= 1'b0;
            r_state    <= S_MANUAL;
            r_presc    <= '0;
            r_step     <= 1'b0;
            r_load     <= 1'b0;
            r_seed     <= LFSR_RST_SEED;
            r_count    <= '0;
        end else begin
            r_deb_d    <= w_deb;
            r_seed_req <= seed_req;
            r_step     <= 1'b0;
            r_load     <= 1'b0;
            // A load pre-empts any step or tick in the same cycle; the dropped one is not replayed.
            if (w_load_event) begin
                r_state <= S_LOAD;
                r_load  <= 1'b1;
                r_seed  <= sanitise_seed(seed);
                r_count <= '0;
                r_presc <= '0;
            end else begin
                case (r_state)
                    S_MANUAL: begin
                        r_presc <= '0;
                        if (w_step_event) begin
                            r_step  <= 1'b1;
                            r_count <= r_count + CNT_W'(1);
                        end
                        if (run_mode) r_state <= S_RUN;
                    end
                    S_RUN: begin
                        if (!run_mode) begin
                            r_state <= S_MANUAL;
                            r_presc <= '0;
                        end else if (r_presc == PW'(RUN_PERIOD - 1)) begin
                            r_presc <= '0;
                            r_step  <= 1'b1;
                            r_count <= r_count + CNT_W'(1);
                        end else begin
                            r_presc <= r_presc + PW'(1);
                        end
                    end
                    S_LOAD: begin
                        r_presc <= '0;
                        r_state <= run_mode ? S_RUN : S_MANUAL;
                    end
                    default: begin
                        r_presc <= '0;
                        r_state <= S_MANUAL;
                    end
                endcase
            end
        end
    end

    assign lfsr_step  = r_step;
    assign lfsr_load  = r_load;
    assign lfsr_seed  = r_seed;
    assign state_o    = r_state;
    assign step_count = r_count;

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// Directed bench for lfsr_step_ctrl: reset, debounce, auto-run, seed loads, collision and count wrap.
// A second instance with a 4-bit counter shares the step/run stimulus for the wrap case.
module tb_lfsr_step_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       step_in;
    logic       run_mode;
    logic       seed_req;
    logic [7:0] seed;
    logic       lfsr_step, lfsr_load;
    logic [7:0] lfsr_seed;
    logic [1:0] state_o;
    logic [15:0] step_count;

    logic       seed_req_w = 1'b0;
    logic       step_w, load_w;
    logic [7:0] seed_w;
    logic [1:0] state_w;
    logic [3:0] count_w;

    int checks = 0;
    int errors = 0;
    int n_both = 0;

    always #5 clk = ~clk;

    lfsr_step_ctrl #(.DEB_CYCLES(16), .RUN_PERIOD(100), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .step_in(step_in), .run_mode(run_mode),
        .seed_req(seed_req), .seed(seed), .lfsr_step(lfsr_step), .lfsr_load(lfsr_load),
        .lfsr_seed(lfsr_seed), .state_o(state_o), .step_count(step_count)
    );

    lfsr_step_ctrl #(.DEB_CYCLES(16), .RUN_PERIOD(100), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .step_in(step_in), .run_mode(run_mode),
        .seed_req(seed_req_w), .seed(seed), .lfsr_step(step_w), .lfsr_load(load_w),
        .lfsr_seed(seed_w), .state_o(state_w), .step_count(count_w)
    );

    always @(negedge clk) begin
        if ((lfsr_step && lfsr_load) || (step_w && load_w)) n_both++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; step_in = 1'b0; run_mode = 1'b0; seed_req = 1'b0; seed = 8'h00;
        repeat (3) tick();
        checks++;
        if ({lfsr_step, lfsr_load, lfsr_seed, state_o, step_count} !== {1'b0, 1'b0, 8'h01, 2'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset_values: got step=%0b load=%0b seed=%h state=%0d count=%0d want 0 0 01 0 0",
                     lfsr_step, lfsr_load, lfsr_seed, state_o, step_count);
        end
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if ({lfsr_step, lfsr_load, state_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release: got step=%0b load=%0b state=%0d want 0 0 0", lfsr_step, lfsr_load, state_o);
        end
        $display("reset: done");
    endtask

    task automatic test_bounce();
        int early = 0;
        int hits  = 0;
        int at    = -1;
        for (int i = 0; i < 10; i++) begin
            step_in = ~step_in;
            repeat (3) begin
                tick();
                if (lfsr_step) early++;
            end
        end
        checks++;
        if (early !== 0) begin
            errors++;
            $display("FAIL bounce_glitch: got %0d strobes during bounce want 0", early);
        end
        step_in = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (lfsr_step) begin hits++; at = c; end
        end
        checks++;
        if (hits !== 1 || at !== 19) begin
            errors++;
            $display("FAIL bounce_strobe: got %0d strobes last at cycle %0d want 1 at 19", hits, at);
        end
        checks++;
        if (step_count !== 16'd1) begin
            errors++;
            $display("FAIL bounce_count: got %0d want 1", step_count);
        end
        step_in = 1'b0;
        repeat (25) tick();
        $display("bounce: strobes=%0d at=%0d count=%0d", hits, at, step_count);
    endtask

    task automatic test_seed();
        seed = 8'hFF; seed_req = 1'b1;
        tick();
        checks++;
        if ({lfsr_load, lfsr_step, lfsr_seed, state_o, step_count} !== {1'b1, 1'b0, 8'h01, 2'd2, 16'd0}) begin
            errors++;
            $display("FAIL seed_lockup: got load=%0b step=%0b seed=%h state=%0d count=%0d want 1 0 01 2 0",
                     lfsr_load, lfsr_step, lfsr_seed, state_o, step_count);
        end
        tick();
        checks++;
        if (lfsr_load !== 1'b0 || state_o !== 2'd0) begin
            errors++;
            $display("FAIL seed_exit: got load=%0b state=%0d want 0 0", lfsr_load, state_o);
        end
        seed_req = 1'b0;
        repeat (2) tick();
        seed = 8'h5A; seed_req = 1'b1;
        tick();
        checks++;
        if (lfsr_load !== 1'b1 || lfsr_seed !== 8'h5A) begin
            errors++;
            $display("FAIL seed_pass: got load=%0b seed=%h want 1 5a", lfsr_load, lfsr_seed);
        end
        seed_req = 1'b0;
        repeat (3) tick();
        $display("seed: loads checked, seed=%h", lfsr_seed);
    endtask

    task automatic test_autorun();
        int hits = 0;
        int bad  = 0;
        run_mode = 1'b1;
        tick();
        checks++;
        if (state_o !== 2'd1) begin
            errors++;
            $display("FAIL run_entry: got state=%0d want 1", state_o);
        end
        for (int c = 1; c <= 1000; c++) begin
            if (c == 300) step_in = 1'b1;
            if (c == 340) step_in = 1'b0;
            if (c == 520) step_in = 1'b1;
            if (c == 560) step_in = 1'b0;
            tick();
            if (lfsr_step) begin
                hits++;
                if (c % 100 != 0) bad++;
            end
        end
        checks++;
        if (hits !== 10 || bad !== 0) begin
            errors++;
            $display("FAIL run_strobes: got %0d strobes %0d off-grid want 10 0", hits, bad);
        end
        checks++;
        if (step_count !== 16'd10) begin
            errors++;
            $display("FAIL run_count: got %0d want 10", step_count);
        end
        $display("autorun: strobes=%0d off_grid=%0d count=%0d", hits, bad, step_count);
    endtask

    task automatic test_collision();
        int hits = 0;
        int at   = -1;
        repeat (99) tick();
        seed = 8'h3C; seed_req = 1'b1;
        tick();
        checks++;
        if ({lfsr_load, lfsr_step, state_o, step_count} !== {1'b1, 1'b0, 2'd2, 16'd0}) begin
            errors++;
            $display("FAIL collision_load: got load=%0b step=%0b state=%0d count=%0d want 1 0 2 0",
                     lfsr_load, lfsr_step, state_o, step_count);
        end
        seed_req = 1'b0;
        for (int c = 1; c <= 110; c++) begin
            tick();
            if (c == 1) begin
                checks++;
                if (state_o !== 2'd1) begin
                    errors++;
                    $display("FAIL collision_exit: got state=%0d want 1", state_o);
                end
            end
            if (lfsr_step) begin hits++; if (at < 0) at = c; end
        end
        checks++;
        if (hits !== 1 || at !== 101) begin
            errors++;
            $display("FAIL collision_next: got %0d strobes first at %0d want 1 at 101", hits, at);
        end
        $display("collision: next strobe at %0d", at);
    endtask

    task automatic test_async_reset();
        run_mode = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({lfsr_step, lfsr_load, lfsr_seed, state_o, step_count, count_w} !==
            {1'b0, 1'b0, 8'h01, 2'd0, 16'd0, 4'd0}) begin
            errors++;
            $display("FAIL async_reset: got step=%0b load=%0b seed=%h state=%0d count=%0d want 0 0 01 0 0",
                     lfsr_step, lfsr_load, lfsr_seed, state_o, step_count);
        end
        tick();
        rst = 1'b0;
        tick();
        $display("async_reset: seed=%h count=%0d", lfsr_seed, step_count);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 17; i++) begin
            step_in = 1'b1;
            repeat (22) tick();
            step_in = 1'b0;
            repeat (22) tick();
        end
        checks++;
        if (count_w !== 4'd1) begin
            errors++;
            $display("FAIL wrap_count4: got %0d want 1", count_w);
        end
        checks++;
        if (step_count !== 16'd17) begin
            errors++;
            $display("FAIL wrap_count16: got %0d want 17", step_count);
        end
        checks++;
        if (n_both !== 0) begin
            errors++;
            $display("FAIL step_and_load: got %0d overlapping cycles want 0", n_both);
        end
        $display("wrap: count4=%0d count16=%0d overlaps=%0d", count_w, step_count, n_both);
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_seed();
        test_autorun();
        test_collision();
        test_async_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
